shift_register_ctrl: RTL

Sequencer that turns a `shift_register` instance into a parallel-in/serial-out stage for bit-serial hyperspectral datapath transfers. It accepts a WIDTH-bit word over a valid/ready handshake, drives the register's `load`/`shift`/`load_data`/`shift_in` controls, and streams the word out one bit per accepted beat. The output stream supports downstream backpressure and carries a last-bit flag. The controller sits between a word producer and the `shift_register`, which is instantiated externally and wired to the `sr_*` ports.

---
 rtl/shift_register_ctrl.sv | 57 +++++
 1 files changed

// File: rtl/shift_register_ctrl.sv
// shift_register_ctrl: sequences an external shift_register as a parallel-in/serial-out stage
module shift_register_ctrl #(
  parameter int WIDTH       = 5,
  parameter bit SHIFT_RIGHT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     sr_load,
  output logic                     sr_shift,
  output logic [WIDTH-1:0]         sr_load_data,
  output logic                     sr_shift_in,
  input  logic [WIDTH-1:0]         sr_out,
  output logic                     out_bit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t        state_q;
  logic [IW-1:0] bit_idx_q;
  logic          beat;
  logic          unused_sr;
  assign busy         = state_q == STREAM;
  assign out_valid    = busy;
  assign out_last     = busy & (bit_idx_q == LAST);
  assign beat         = out_valid & out_ready;
  assign in_ready     = ~rst & (~busy | (beat & out_last));
  assign sr_load      = in_valid & in_ready;
  assign sr_shift     = beat & ~out_last;
  assign sr_load_data = in_data;
  assign sr_shift_in  = 1'b0;
  assign out_bit      = SHIFT_RIGHT ? sr_out[0] : sr_out[WIDTH-1];
  assign bit_idx      = bit_idx_q;
  assign unused_sr    = ^sr_out;
  // Word accept restarts the bit index, non-final beats advance it, a final beat without a new word ends the stream
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
    end else if (sr_load) begin
      state_q   <= STREAM;
      bit_idx_q <= '0;
    end else if (sr_shift) begin
      bit_idx_q <= bit_idx_q + IW'(1);
    end else if (beat) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
    end
  end
endmodule
